// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// One anode is driven at a time with a blanking gap at the start of each slot;
// new frames are staged in a shadow copy and committed only at frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } slot_state_t;

  // cnt resets to 0, which is a blanking cycle unless blanking is disabled
  localparam slot_state_t ST_INIT = (BLANK_CYCLES != 0) ? ST_BLANK : ST_SHOW;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes render dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b1111111;
    endcase
    return pattern;
  endfunction

  logic [CNT_W-1:0]                cnt;
  logic [CNT_W-1:0]                cnt_next;
  logic [IDX_W-1:0]                idx;
  logic                            cnt_wrap;
  logic                            boundary;
  slot_state_t                     state;
  slot_state_t                     state_next;

  logic [NUM_DIGITS-1:0][3:0]      disp;
  logic [NUM_DIGITS-1:0]           disp_dp;
  logic                            disp_lz;
  logic [NUM_DIGITS-1:0][3:0]      shadow;
  logic [NUM_DIGITS-1:0]           shadow_dp;
  logic                            shadow_lz;
  logic                            pending;

  logic [NUM_DIGITS-1:0]           lz_mask;
  logic                            zero_run;
  logic [NUM_DIGITS-1:0]           an_next;
  logic [6:0]                      seg_next;
  logic                            dp_next;

  assign cnt_wrap = (cnt == CNT_LAST);
  assign boundary = cnt_wrap && (idx == IDX_LAST);
  assign cnt_next = cnt_wrap ? '0 : cnt + 1'b1;

  // Slot prescaler and digit index: idx advances once per cnt wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_next;
      if (cnt_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Slot phase register; it always describes the current value of cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Phase of the upcoming cnt value: blank for the first BLANK_CYCLES counts
  always_comb begin
    state_next = ST_SHOW;
    if ((BLANK_CYCLES != 0) && (cnt_next < BLANK_END)) begin
      state_next = ST_BLANK;
    end
  end

  // Shadow capture on load and tear-free commit at the frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp      <= '0;
      disp_dp   <= '0;
      disp_lz   <= 1'b0;
      shadow    <= '0;
      shadow_dp <= '0;
      shadow_lz <= 1'b0;
      pending   <= 1'b0;
    end else begin
      // the commit uses the shadow from before this cycle's load
      if (boundary && pending) begin
        disp    <= shadow;
        disp_dp <= shadow_dp;
        disp_lz <= shadow_lz;
      end
      if (load) begin
        shadow    <= digits_in;
        shadow_dp <= dp_in;
        shadow_lz <= lz_en;
        pending   <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  // Leading-zero mask: a digit is dark when it and every digit above it are zero
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (disp[i] == 4'd0);
      lz_mask[i] = disp_lz & zero_run;
    end
  end

  // Next pin values for the current slot phase; dark whenever no anode is on
  always_comb begin
    an_next  = '1;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (state == ST_SHOW) begin
      an_next  = ~(NUM_DIGITS'(1) << idx);
      seg_next = lz_mask[idx] ? 7'h7F : seg_decode(disp[idx]);
      dp_next  = ~disp_dp[idx];
    end
  end

  // Registered pin drivers and end-of-frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl (8 digits, 8-cycle slots, 2 blank cycles).
// A frame-level reference model predicts every output cycle from the cycle position.
module tb_seven_seg_scan_ctrl;

  localparam int N  = 8;
  localparam int P  = 8;
  localparam int B  = 2;
  localparam int FR = N * P;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]  dp_in;
  logic          lz_en;
  logic [N-1:0]  an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_done;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .PRESCALE    (P),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .lz_en     (lz_en),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state: visible frame, staged frame, and cycle position
  logic [31:0] m_disp, m_sh;
  logic [7:0]  m_dp, m_shdp;
  logic        m_lz, m_shlz, m_pend;
  int unsigned pos;

  function automatic logic [6:0] seg_ref(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // expected {an, seg, dp, frame_done} after the edge that consumes position p
  function automatic logic [16:0] expect_out(input int unsigned p);
    int unsigned phase, slot, digit;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fd, supp;
    phase = p % P;
    slot  = (p / P) % N;
    e_fd  = ((p % FR) == FR - 1);
    e_an  = 8'hFF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (phase >= B) begin
      digit = (m_disp >> (4 * slot)) & 32'hF;
      supp  = m_lz && (slot != 0) && ((m_disp >> (4 * slot)) == 32'd0);
      e_an  = 8'hFF ^ (8'd1 << slot);
      e_seg = supp ? 7'h7F : seg_ref(digit);
      e_dp  = ~m_dp[slot];
    end
    return {e_an, e_seg, e_dp, e_fd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_disp = '0; m_sh = '0; m_dp = '0; m_shdp = '0;
    m_lz = 1'b0; m_shlz = 1'b0; m_pend = 1'b0; pos = 0;
  endtask

  // one clock: apply inputs, check the predicted outputs, then advance the model
  task automatic tick(input logic ld, input logic [31:0] d, input logic [7:0] dpi, input logic lz);
    logic [16:0] e;
    load = ld; digits_in = d; dp_in = dpi; lz_en = lz;
    e = expect_out(pos);
    @(posedge clk);
    #1;
    chk($sformatf("scan pos=%0d", pos), {15'd0, an, seg, dp, frame_done}, {15'd0, e});
    load = 1'b0;
    if (((pos % FR) == FR - 1) && m_pend) begin
      m_disp = m_sh; m_dp = m_shdp; m_lz = m_shlz; m_pend = 1'b0;
    end
    if (ld) begin
      m_sh = d; m_shdp = dpi; m_shlz = lz; m_pend = 1'b1;
    end
    pos++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, $urandom, 8'($urandom), 1'($urandom));
  endtask

  task automatic idle_until(input int unsigned ph);
    for (int k = 0; k < FR && (pos % FR) != ph; k++) idle(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with noisy inputs
    rst_n = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0; lz_en = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      load = 1'($urandom); digits_in = $urandom; dp_in = 8'($urandom); lz_en = 1'($urandom);
    end
    #1;
    chk("rst_an", {24'd0, an}, 32'hFF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b1;

    // first slot after release: two blank cycles then digit 0 (cleared to 0)
    idle(3);
    chk("first_show_an", {24'd0, an}, 32'hFE);
    chk("first_show_seg", {25'd0, seg}, 32'h40);

    // plain scan of 8..1
    tick(1'b1, 32'h87654321, 8'h00, 1'b0);
    idle(2 * FR + 10);

    // tearing: 1s loaded early, 2s loaded mid-frame after 1s committed
    idle_until(10);
    tick(1'b1, 32'h11111111, 8'h00, 1'b0);
    idle_until(0);
    idle(20);
    tick(1'b1, 32'h22222222, 8'h00, 1'b0);
    idle(FR + 20);

    // leading-zero suppression
    tick(1'b1, 32'h00000305, 8'h00, 1'b1);
    idle(FR + 70);
    tick(1'b1, 32'h00000000, 8'h00, 1'b1);
    idle(FR + 70);

    // invalid digit with decimal point
    tick(1'b1, 32'h0000C000, 8'h08, 1'b0);
    idle(FR + 70);

    // load in the boundary cycle lands one frame later; repeated loads, last wins
    idle_until(FR - 1);
    tick(1'b1, 32'h13572468, 8'hA5, 1'b0);
    idle(FR + 10);
    tick(1'b1, 32'h99999999, 8'h00, 1'b0);
    idle(5);
    tick(1'b1, 32'h24680135, 8'h3C, 1'b1);
    idle(FR + 10);

    // asynchronous reset with cnt=5, idx=4
    idle_until(4 * P + 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", {24'd0, an}, 32'hFF);
    chk("async_rst_seg", {25'd0, seg}, 32'h7F);
    chk("async_rst_dp", {31'd0, dp}, 32'd1);
    chk("async_rst_fd", {31'd0, frame_done}, 32'd0);
    @(posedge clk);
    #1;
    chk("async_hold_an", {24'd0, an}, 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(3);
    chk("restart_an", {24'd0, an}, 32'hFE);
    chk("restart_seg", {25'd0, seg}, 32'h40);

    // randomized loads at arbitrary points
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0)
        tick(1'b1, $urandom, 8'($urandom), 1'($urandom));
      else
        idle(1);
    end
    // mostly-zero random frames exercise suppression more often
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, $urandom & (32'hFFFFFFFF >> (4 * $urandom_range(1, 7))), 8'($urandom), 1'b1);
      idle(FR);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
